// File: rtl/gray_conv_sched.sv
// Shared binary<->Gray converter behind a 4-way round-robin arbiter; B2G done 2 cycles after grant sample, G2B after W.
// No backpressure: requests are only sampled in IDLE; requesters keep req high until they see their done_id.
module gray_conv_sched #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [3:0]     mode,
  input  logic [4*W-1:0] din,
  output logic [3:0]     grant,
  output logic           busy,
  output logic [W-1:0]   dout,
  output logic           done,
  output logic [1:0]     done_id
);

  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {IDLE, B2G, G2B, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, owner, win;
  logic [W-1:0]  din_sel, opnd, res, res_step, b2g_val;
  logic [KW-1:0] k;

  // The last write in the descending scan is the first asserted bit after ptr.
  always_comb begin
    win = ptr;
    for (int o = 4; o >= 1; o--) begin
      if (req[ptr + 2'(o)]) win = ptr + 2'(o);
    end
  end

  assign din_sel = din[win*W +: W];
  assign b2g_val = opnd ^ (opnd >> 1);

  // One Gray->binary step: resolve bit k from the already resolved bit above it.
  always_comb begin
    res_step = res;
    for (int i = 0; i < W-1; i++) begin
      if (KW'(i) == k) res_step[i] = res[i+1] ^ opnd[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|req) state_nxt = mode[win] ? G2B : B2G;
      B2G:  state_nxt = DONE;
      G2B:  if (k == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    grant = '0;
    if (state != IDLE) grant[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 2'd3;
      owner   <= '0;
      opnd    <= '0;
      res     <= '0;
      k       <= '0;
      dout    <= '0;
      done_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            opnd  <= din_sel;
            owner <= win;
            ptr   <= win;
            res   <= {din_sel[W-1], {(W-1){1'b0}}};
            k     <= KW'(W-2);
          end
        end
        B2G: begin
          res     <= b2g_val;
          dout    <= b2g_val;
          done_id <= owner;
        end
        G2B: begin
          res <= res_step;
          k   <= k - 1'b1;
          if (k == '0) begin
            dout    <= res_step;
            done_id <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
